ram_rw_mux: RTL and testbench

Parametrised SPI-to-RAM access controller, next generation of the host loader path. It decodes the command/data byte stream from the SPI slave and holds the CPU in reset or releases it. It drives byte-granular writes and reads into N_RAM independently selectable RAM banks, with a host-settable, auto-incrementing byte pointer and read-back of RAM bytes to the SPI transmit side.

---
 rtl/ram_rw_mux.sv | 158 +++++++++++++++
 tb/tb_ram_rw_mux.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rw_mux.sv
// SPI command/data byte decoder that drives banked, byte-lane RAM writes and reads,
// keeps the CPU in reset or lets it run, and returns read bytes to the SPI side.
module ram_rw_mux #(
  parameter  int XLEN  = 32,
  parameter  int N_RAM = 2,
  parameter  int AW    = 16,
  localparam int BYTES = XLEN / 8,
  localparam int LB    = $clog2(BYTES),
  localparam int LBW   = (LB > 0) ? LB : 1,
  localparam int PW    = AW + LB
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    dc_i,
  input  logic                    spi_byte_vld_i,
  input  logic [7:0]              spi_byte_data_i,
  input  logic [N_RAM*XLEN-1:0]   ram_rd_data_i,
  output logic                    cpu_rst_n_o,
  output logic [N_RAM-1:0]        ram_sel_o,
  output logic                    ram_wr_en_o,
  output logic                    ram_rd_en_o,
  output logic [AW-1:0]           ram_addr_o,
  output logic [BYTES-1:0]        ram_wr_byte_en_o,
  output logic [XLEN-1:0]         ram_wr_data_o,
  output logic [7:0]              spi_tx_byte_o,
  output logic                    spi_byte_rdy_o,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_ADDR} mode_t;

  mode_t            r_mode, w_mode_nxt, r_ret;
  logic [3:0]       r_bank, r_bank1, r_bank2;
  logic             r_bank_vld, r_cpu_rst_n;
  logic [PW-1:0]    r_ptr;
  logic [1:0]       r_cnt;
  logic [31:0]      r_sh;
  logic             r_wr_en, r_rd_en;
  logic [AW-1:0]    r_addr;
  logic [BYTES-1:0] r_ben;
  logic [XLEN-1:0]  r_wdata;
  logic             r_v1, r_v2, r_rdy, r_rd1, r_rd2;
  logic [LBW-1:0]   r_lane1, r_lane2;
  logic [7:0]       r_tx;

  logic             w_cmd, w_dat, w_k_ok, w_is_wr, w_is_rd, w_is_rst, w_is_run, w_is_set;
  logic [LBW-1:0]   w_lane;
  logic [AW-1:0]    w_word;
  logic [31:0]      w_sh_nxt;
  logic [7:0]       w_rd_byte;

  assign w_cmd    = spi_byte_vld_i & ~dc_i;
  assign w_dat    = spi_byte_vld_i & dc_i;
  assign w_k_ok   = int'(spi_byte_data_i[3:0]) < N_RAM;
  assign w_is_wr  = (spi_byte_data_i[7:4] == 4'h4) && w_k_ok;
  assign w_is_rd  = (spi_byte_data_i[7:4] == 4'h5) && w_k_ok;
  assign w_is_rst = spi_byte_data_i == 8'h2a;
  assign w_is_run = spi_byte_data_i == 8'h2b;
  assign w_is_set = spi_byte_data_i == 8'h60;
  assign w_lane   = (LB > 0) ? r_ptr[LBW-1:0] : '0;
  assign w_word   = AW'(r_ptr >> LB);
  assign w_sh_nxt = {spi_byte_data_i, r_sh[31:8]};
  // Read lane and bank come from the pipelined request, not the live mode state.
  assign w_rd_byte = ram_rd_data_i[int'(r_bank2)*XLEN + int'(r_lane2)*8 +: 8];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_mode <= S_IDLE;
    else          r_mode <= w_mode_nxt;
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_cmd) begin
      if (w_is_wr)       w_mode_nxt = S_WR;
      else if (w_is_rd)  w_mode_nxt = S_RD;
      else if (w_is_set) w_mode_nxt = S_ADDR;
      else               w_mode_nxt = S_IDLE;
    end else if (w_dat && r_mode == S_ADDR && r_cnt == 2'd3) begin
      w_mode_nxt = r_ret;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ret <= S_IDLE;       r_bank <= '0;     r_bank_vld <= 1'b0;
      r_cpu_rst_n <= 1'b0;   r_ptr <= '0;      r_cnt <= '0;
      r_sh <= '0;            r_wr_en <= 1'b0;  r_rd_en <= 1'b0;
      r_addr <= '0;          r_ben <= '0;      r_wdata <= '0;
      r_v1 <= 1'b0;          r_v2 <= 1'b0;     r_rdy <= 1'b0;
      r_rd1 <= 1'b0;         r_rd2 <= 1'b0;    r_lane1 <= '0;
      r_lane2 <= '0;         r_bank1 <= '0;    r_bank2 <= '0;
      r_tx <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_ben   <= '0;
      r_rd1   <= 1'b0;
      r_v1    <= spi_byte_vld_i;
      r_v2    <= r_v1;
      r_rdy   <= r_v2;
      r_rd2   <= r_rd1;
      r_lane2 <= r_lane1;
      r_bank2 <= r_bank1;
      if (r_rd2) r_tx <= w_rd_byte;
      if (w_cmd) begin
        r_cpu_rst_n <= w_is_run;
        if (w_is_rst || w_is_run) begin
          r_ptr      <= '0;
          r_bank_vld <= 1'b0;
        end else if (w_is_wr || w_is_rd) begin
          r_bank     <= spi_byte_data_i[3:0];
          r_bank_vld <= 1'b1;
        end else if (w_is_set) begin
          r_cnt <= '0;
          if (r_mode != S_ADDR) r_ret <= r_mode;
        end else begin
          r_bank_vld <= 1'b0;
        end
      end else if (w_dat) begin
        case (r_mode)
          S_WR: begin
            r_wr_en <= 1'b1;
            r_addr  <= w_word;
            r_ben   <= BYTES'(1) << w_lane;
            r_wdata <= {BYTES{spi_byte_data_i}};
            r_ptr   <= r_ptr + PW'(1);
          end
          S_RD: begin
            r_rd_en <= 1'b1;
            r_addr  <= w_word;
            r_rd1   <= 1'b1;
            r_lane1 <= w_lane;
            r_bank1 <= r_bank;
            r_ptr   <= r_ptr + PW'(1);
          end
          S_ADDR: begin
            r_sh  <= w_sh_nxt;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) r_ptr <= w_sh_nxt[PW-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign cpu_rst_n_o      = r_cpu_rst_n;
  assign ram_sel_o        = r_bank_vld ? (N_RAM'(1) << r_bank) : '0;
  assign ram_wr_en_o      = r_wr_en;
  assign ram_rd_en_o      = r_rd_en;
  assign ram_addr_o       = r_addr;
  assign ram_wr_byte_en_o = r_ben;
  assign ram_wr_data_o    = r_wdata;
  assign spi_tx_byte_o    = r_tx;
  assign spi_byte_rdy_o   = r_rdy;
  assign dbg_state_o      = r_mode;

endmodule

// File: tb/tb_ram_rw_mux.sv
// Bench for ram_rw_mux: directed byte streams, a cycle-indexed expectation model,
// a RAM stub with one-cycle read latency, and literal spot checks.
module tb_ram_rw_mux;
  localparam int XLEN = 32, NR = 2, AW = 16, MAXC = 1024;
  localparam int MASK = (1 << 18) - 1;
  localparam int M_IDLE = 0, M_WR = 1, M_RD = 2, M_ADDR = 3;

  logic clk_i = 1'b0, rst_n_i = 1'b0, dc_i = 1'b0, spi_byte_vld_i = 1'b0;
  logic [7:0] spi_byte_data_i = '0;
  logic [NR*XLEN-1:0] ram_rd_data_i;
  logic cpu_rst_n_o, ram_wr_en_o, ram_rd_en_o, spi_byte_rdy_o;
  logic [NR-1:0] ram_sel_o;
  logic [AW-1:0] ram_addr_o;
  logic [3:0] ram_wr_byte_en_o;
  logic [XLEN-1:0] ram_wr_data_o;
  logic [7:0] spi_tx_byte_o;
  logic [1:0] dbg_state_o;

  ram_rw_mux #(.XLEN(XLEN), .N_RAM(NR), .AW(AW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .dc_i(dc_i), .spi_byte_vld_i(spi_byte_vld_i),
    .spi_byte_data_i(spi_byte_data_i), .ram_rd_data_i(ram_rd_data_i),
    .cpu_rst_n_o(cpu_rst_n_o), .ram_sel_o(ram_sel_o), .ram_wr_en_o(ram_wr_en_o),
    .ram_rd_en_o(ram_rd_en_o), .ram_addr_o(ram_addr_o), .ram_wr_byte_en_o(ram_wr_byte_en_o),
    .ram_wr_data_o(ram_wr_data_o), .spi_tx_byte_o(spi_tx_byte_o),
    .spi_byte_rdy_o(spi_byte_rdy_o), .dbg_state_o(dbg_state_o));

  // clock / reset
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // RAM stub: one-cycle registered read, byte-lane writes into the selected bank
  logic [31:0] ram [int];
  logic [31:0] rd_q [NR];
  initial for (int k = 0; k < NR; k++) rd_q[k] = '0;
  assign ram_rd_data_i = {rd_q[1], rd_q[0]};
  always @(posedge clk_i) begin
    logic [31:0] w;
    int key;
    for (int k = 0; k < NR; k++) begin
      key = k * 65536 + int'(ram_addr_o);
      w = ram.exists(key) ? ram[key] : 32'h0;
      if (ram_rd_en_o) rd_q[k] <= w;
      if (ram_wr_en_o && ram_sel_o[k]) begin
        for (int b = 0; b < 4; b++)
          if (ram_wr_byte_en_o[b]) w[b*8 +: 8] = ram_wr_data_o[b*8 +: 8];
        ram[key] = w;
      end
    end
  end

  // behavioural model: per-cycle expectations derived from the command rules
  bit          e_wr [MAXC], e_rd [MAXC], e_rdy [MAXC], e_cpu [MAXC];
  logic [15:0] e_addr [MAXC];
  logic [3:0]  e_ben [MAXC];
  logic [31:0] e_wdata [MAXC];
  logic [1:0]  e_sel [MAXC];
  logic [7:0]  e_tx [MAXC];
  logic [31:0] mmem [int];
  int m_mode, m_ret, m_bank, m_cnt;
  bit m_bvld, m_cpu;
  int unsigned m_ptr, m_sh;

  task automatic model_clear(input int from);
    for (int c = from; c < MAXC; c++) begin
      e_wr[c] = 0; e_rd[c] = 0; e_rdy[c] = 0; e_cpu[c] = 0;
      e_addr[c] = '0; e_ben[c] = '0; e_wdata[c] = '0; e_sel[c] = '0; e_tx[c] = '0;
    end
    m_mode = M_IDLE; m_ret = M_IDLE; m_bank = 0; m_cnt = 0;
    m_bvld = 0; m_cpu = 0; m_ptr = 0; m_sh = 0;
  endtask

  task automatic model_byte(input bit dc, input logic [7:0] b, input int base);
    int k, key;
    logic [31:0] w;
    e_rdy[base+3] = 1'b1;
    if (!dc) begin
      k = int'(b[3:0]);
      m_cpu = 0;
      if (b == 8'h2a || b == 8'h2b) begin
        m_cpu = (b == 8'h2b); m_mode = M_IDLE; m_ptr = 0; m_bvld = 0;
      end else if (b[7:4] == 4'h4 && k < NR) begin
        m_mode = M_WR; m_bank = k; m_bvld = 1;
      end else if (b[7:4] == 4'h5 && k < NR) begin
        m_mode = M_RD; m_bank = k; m_bvld = 1;
      end else if (b == 8'h60) begin
        if (m_mode != M_ADDR) m_ret = m_mode;
        m_mode = M_ADDR; m_cnt = 0; m_sh = 0;
      end else begin
        m_mode = M_IDLE; m_bvld = 0;
      end
      for (int c = base + 1; c < MAXC; c++) begin
        e_cpu[c] = m_cpu;
        e_sel[c] = m_bvld ? 2'(1 << m_bank) : 2'b00;
      end
    end else begin
      key = m_bank * 65536 + int'(m_ptr / 4);
      w = mmem.exists(key) ? mmem[key] : 32'h0;
      if (m_mode == M_WR) begin
        e_wr[base+1] = 1; e_addr[base+1] = 16'(m_ptr / 4);
        e_ben[base+1] = 4'(1 << (m_ptr % 4)); e_wdata[base+1] = {4{b}};
        w[(m_ptr % 4) * 8 +: 8] = b;
        mmem[key] = w;
        m_ptr = (m_ptr + 1) & MASK;
      end else if (m_mode == M_RD) begin
        e_rd[base+1] = 1; e_addr[base+1] = 16'(m_ptr / 4);
        for (int c = base + 3; c < MAXC; c++) e_tx[c] = w[(m_ptr % 4) * 8 +: 8];
        m_ptr = (m_ptr + 1) & MASK;
      end else if (m_mode == M_ADDR) begin
        m_sh = (m_sh >> 8) | (32'(b) << 24);
        m_cnt++;
        if (m_cnt == 4) begin m_ptr = m_sh & MASK; m_mode = m_ret; end
      end
    end
  endtask

  // scoreboard
  int n_vec = 0, n_err = 0;
  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    int c;
    c = cyc;
    if (c < MAXC) begin
      chk("cpu_rst_n", c, 32'(cpu_rst_n_o), 32'(e_cpu[c]));
      chk("ram_sel", c, 32'(ram_sel_o), 32'(e_sel[c]));
      chk("wr_en", c, 32'(ram_wr_en_o), 32'(e_wr[c]));
      chk("rd_en", c, 32'(ram_rd_en_o), 32'(e_rd[c]));
      chk("byte_en", c, 32'(ram_wr_byte_en_o), 32'(e_ben[c]));
      chk("rdy", c, 32'(spi_byte_rdy_o), 32'(e_rdy[c]));
      chk("tx_byte", c, 32'(spi_tx_byte_o), 32'(e_tx[c]));
      if (e_wr[c] || e_rd[c]) chk("addr", c, 32'(ram_addr_o), 32'(e_addr[c]));
      if (e_wr[c]) chk("wr_data", c, ram_wr_data_o, e_wdata[c]);
    end
  end

  // observation log for literal spot checks
  logic [31:0] l_wdata [MAXC];
  logic [15:0] l_addr [MAXC];
  logic [7:0]  l_tx [MAXC];
  logic [3:0]  l_ben [MAXC];
  logic [1:0]  l_sel [MAXC];
  logic        l_wr [MAXC], l_rdy [MAXC], l_cpu [MAXC];
  always @(negedge clk_i) if (cyc < MAXC) begin
    l_wdata[cyc] = ram_wr_data_o; l_addr[cyc] = ram_addr_o; l_tx[cyc] = spi_tx_byte_o;
    l_ben[cyc] = ram_wr_byte_en_o; l_sel[cyc] = ram_sel_o; l_wr[cyc] = ram_wr_en_o;
    l_rdy[cyc] = spi_byte_rdy_o; l_cpu[cyc] = cpu_rst_n_o;
  end

  // driver tasks
  int base;
  task automatic send(input bit dc, input logic [7:0] b);
    @(posedge clk_i); #1;
    spi_byte_vld_i = 1'b1; dc_i = dc; spi_byte_data_i = b;
    base = cyc;
    model_byte(dc, b, cyc);
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; spi_byte_vld_i = 1'b0; end
  endtask

  int b_run, b_rst, r0, r3, w0, w3, w4, wa, wb, wc, wd, wx, wy, rb, wr_base;

  initial begin
    model_clear(0);
    ram[0] = 32'hDEADBEEF; mmem[0] = 32'hDEADBEEF;
    ram[65536] = 32'h01020304; mmem[65536] = 32'h01020304;
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    send(0, 8'h2b); b_run = base;
    send(0, 8'h2a); b_rst = base;
    idle(4);

    send(0, 8'h50);
    send(1, 8'h00); r0 = base;
    send(1, 8'h00); send(1, 8'h00);
    send(1, 8'h00); r3 = base;
    idle(5);

    send(0, 8'h2a); send(0, 8'h40);
    send(1, 8'h11); w0 = base;
    send(1, 8'h22); send(1, 8'h33);
    send(1, 8'h44); w3 = base;
    send(1, 8'h55); w4 = base;
    idle(4);

    send(0, 8'h41); send(0, 8'h60);
    send(1, 8'h06); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00);
    send(1, 8'hAA); wa = base;
    idle(4);

    send(0, 8'h60); send(1, 8'h10); send(1, 8'h00);
    send(0, 8'h40); send(1, 8'h77); wb = base;
    idle(4);
    send(0, 8'h60); send(1, 8'h03); send(1, 8'h00); send(0, 8'h2b);
    idle(4);

    send(0, 8'h40); send(0, 8'h60);
    send(1, 8'hFF); send(1, 8'hFF); send(1, 8'hFF); send(1, 8'hFF);
    send(1, 8'h12); wc = base;
    send(1, 8'h34); wd = base;
    idle(4);

    send(0, 8'h42); send(1, 8'h55); wx = base;
    send(0, 8'h99); send(1, 8'h56); wy = base;
    idle(4);

    send(0, 8'h51); send(1, 8'h00); rb = base;
    idle(5);

    send(0, 8'h40); send(1, 8'h66); wr_base = base;
    @(posedge clk_i); #1;
    spi_byte_vld_i = 1'b0; rst_n_i = 1'b0;
    model_clear(cyc);
    repeat (4) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    send(0, 8'h2b);
    idle(5);

    chk("lit_reset_cpu", 2, 32'(l_cpu[2]), 32'h0);
    chk("lit_run_cpu", b_run + 1, 32'(l_cpu[b_run+1]), 32'h1);
    chk("lit_rst_cpu", b_rst + 1, 32'(l_cpu[b_rst+1]), 32'h0);
    chk("lit_run_rdy", b_run + 3, 32'(l_rdy[b_run+3]), 32'h1);
    chk("lit_rd_tx0", r0 + 3, 32'(l_tx[r0+3]), 32'hEF);
    chk("lit_rd_tx1", r0 + 4, 32'(l_tx[r0+4]), 32'hBE);
    chk("lit_rd_tx2", r0 + 5, 32'(l_tx[r0+5]), 32'hAD);
    chk("lit_rd_tx3", r3 + 3, 32'(l_tx[r3+3]), 32'hDE);
    chk("lit_rd_rdy", r3 + 3, 32'(l_rdy[r3+3]), 32'h1);
    chk("lit_wr_data", w0 + 1, l_wdata[w0+1], 32'h11111111);
    chk("lit_wr_ben0", w0 + 1, 32'(l_ben[w0+1]), 32'h1);
    chk("lit_wr_sel", w0 + 1, 32'(l_sel[w0+1]), 32'h1);
    chk("lit_wr_ben3", w3 + 1, 32'(l_ben[w3+1]), 32'h8);
    chk("lit_wr_addr4", w4 + 1, 32'(l_addr[w4+1]), 32'h1);
    chk("lit_wr_ben4", w4 + 1, 32'(l_ben[w4+1]), 32'h1);
    chk("lit_setaddr_addr", wa + 1, 32'(l_addr[wa+1]), 32'h1);
    chk("lit_setaddr_ben", wa + 1, 32'(l_ben[wa+1]), 32'h4);
    chk("lit_setaddr_sel", wa + 1, 32'(l_sel[wa+1]), 32'h2);
    chk("lit_abort_ben", wb + 1, 32'(l_ben[wb+1]), 32'h8);
    chk("lit_wrap_addr_hi", wc + 1, 32'(l_addr[wc+1]), 32'hFFFF);
    chk("lit_wrap_ben_hi", wc + 1, 32'(l_ben[wc+1]), 32'h8);
    chk("lit_wrap_addr_lo", wd + 1, 32'(l_addr[wd+1]), 32'h0);
    chk("lit_wrap_ben_lo", wd + 1, 32'(l_ben[wd+1]), 32'h1);
    chk("lit_bad_bank_wr", wx + 1, 32'(l_wr[wx+1]), 32'h0);
    chk("lit_bad_bank_sel", wx + 1, 32'(l_sel[wx+1]), 32'h0);
    chk("lit_unknown_wr", wy + 1, 32'(l_wr[wy+1]), 32'h0);
    chk("lit_bank1_tx", rb + 3, 32'(l_tx[rb+3]), 32'h03);
    chk("lit_arst_wr", wr_base + 1, 32'(l_wr[wr_base+1]), 32'h0);
    chk("lit_arst_tx", wr_base + 2, 32'(l_tx[wr_base+2]), 32'h0);
    chk("lit_arst_rdy", wr_base + 3, 32'(l_rdy[wr_base+3]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
